// File: rtl/pwm_pkg.sv
// Shared types and reset constants for the multi-channel PWM compare unit.
package pwm_pkg;

    // Counting scheme of the shared timebase.
    typedef enum logic {
        PWM_EDGE   = 1'b0,  // sawtooth 0..PR, wrap to 0
        PWM_CENTER = 1'b1   // triangle 0..PR..0
    } pwm_mode_e;

    // Slope of the timer in center-aligned mode; stays DIR_UP in edge mode.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam pwm_mode_e RST_MODE  = PWM_EDGE;
    localparam pwm_dir_e  RST_DIR   = DIR_UP;
    localparam logic      RST_LEVEL = 1'b0;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: double-buffered duty, registered compare level and
// output polarity. The shadow duty is written at any time; the active duty
// is refreshed from it whenever the timebase signals a load.
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] tmr,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_wr,
    input  logic             polarity,
    output logic             pwm_out
);

    logic [WIDTH-1:0] duty_sh;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] duty_sh_nx;
    logic             level;

    // Shadow value including a write in this cycle, so a load in the same
    // cycle picks the freshly written duty up (write-through).
    always_comb begin
        duty_sh_nx = duty_wr ? duty_in : duty_sh;
    end

    // Duty registers and the compare level; the level holds while paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh  <= '0;
            duty_act <= '0;
            level    <= RST_LEVEL;
        end else begin
            duty_sh <= duty_sh_nx;
            if (load) begin
                duty_act <= duty_sh_nx;
            end
            if (en) begin
                level <= (tmr < duty_act);
            end
        end
    end

    assign pwm_out = level ^ polarity;

endmodule

// File: rtl/pwm_compare_unit.sv
// Multi-channel PWM timebase. One shared timer (edge- or center-aligned)
// drives CHANNELS duty comparators. Period and mode are double-buffered and
// move from shadow to active at the period boundary, or every cycle while
// the timer is stopped so configuration written before start applies at once.
module pwm_compare_unit
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode_in,
    input  logic [WIDTH-1:0]    period_in,
    input  logic                period_wr,
    input  logic [WIDTH-1:0]    duty_in,
    input  logic [SELW-1:0]     duty_sel,
    input  logic                duty_wr,
    input  logic [CHANNELS-1:0] polarity,
    output logic [WIDTH-1:0]    tmr,
    output logic                period_evt,
    output logic [CHANNELS-1:0] pwm_out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    pwm_mode_e        mode_sh;
    pwm_mode_e        mode_act;
    pwm_mode_e        mode_sh_nx;
    logic [WIDTH-1:0] pr_sh;
    logic [WIDTH-1:0] pr_act;
    logic [WIDTH-1:0] pr_sh_nx;
    pwm_dir_e         dir;
    pwm_dir_e         dir_nx;
    logic [WIDTH-1:0] tmr_nx;
    logic             boundary;
    logic             load;

    // Shadow values including a same-cycle write (write-through on load).
    always_comb begin
        pr_sh_nx   = period_wr ? period_in : pr_sh;
        mode_sh_nx = period_wr ? pwm_mode_e'(mode_in) : mode_sh;
    end

    // Period boundary decode from registered state. Edge mode uses >= so a
    // period shrunk below the held timer during a pause still wraps cleanly.
    always_comb begin
        if (mode_act == PWM_EDGE) begin
            boundary = (tmr >= pr_act);
        end else begin
            boundary = (pr_act == '0) || ((tmr == '0) && (dir == DIR_DOWN));
        end
    end

    assign period_evt = en & boundary;
    assign load       = boundary | ~en;

    // Next timer value and slope. At a boundary the new period/mode take
    // over: a mode switch restarts from 0 going up, otherwise center mode
    // continues its up slope from 1.
    always_comb begin
        tmr_nx = tmr;
        dir_nx = dir;
        if (en) begin
            if (boundary) begin
                dir_nx = DIR_UP;
                if ((mode_sh_nx != mode_act) || (mode_sh_nx == PWM_EDGE) || (pr_sh_nx == '0)) begin
                    tmr_nx = '0;
                end else begin
                    tmr_nx = ONE;
                end
            end else if (mode_act == PWM_EDGE) begin
                tmr_nx = tmr + ONE;
            end else if (dir == DIR_UP) begin
                if (tmr >= pr_act) begin
                    tmr_nx = tmr - ONE;
                    dir_nx = DIR_DOWN;
                end else begin
                    tmr_nx = tmr + ONE;
                end
            end else begin
                tmr_nx = tmr - ONE;
            end
        end
    end

    // Timer, slope, and the shadow/active period and mode registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr      <= '0;
            dir      <= RST_DIR;
            pr_sh    <= '1;
            pr_act   <= '1;
            mode_sh  <= RST_MODE;
            mode_act <= RST_MODE;
        end else begin
            tmr     <= tmr_nx;
            dir     <= dir_nx;
            pr_sh   <= pr_sh_nx;
            mode_sh <= mode_sh_nx;
            if (load) begin
                pr_act   <= pr_sh_nx;
                mode_act <= mode_sh_nx;
            end
        end
    end

    // One comparator per channel; a duty_sel beyond the last channel
    // matches no instance and the write is dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel_cmp #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .load    (load),
            .tmr     (tmr),
            .duty_in (duty_in),
            .duty_wr (duty_wr && (int'(duty_sel) == i)),
            .polarity(polarity[i]),
            .pwm_out (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_compare_unit.sv
// Bench for pwm_compare_unit (3 channels so that duty_sel=3 is out of range).
// The reference model tracks the position inside the period as a phase
// index and folds it into a triangle for center mode.
module tb_pwm_compare_unit;

  localparam int W  = 16;
  localparam int CH = 3;
  localparam int EW = W + 1 + CH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       = 1'b1;
  logic          en        = 1'b0;
  logic          mode_in   = 1'b0;
  logic [W-1:0]  period_in = '0;
  logic          period_wr = 1'b0;
  logic [W-1:0]  duty_in   = '0;
  logic [1:0]    duty_sel  = '0;
  logic          duty_wr   = 1'b0;
  logic [CH-1:0] polarity  = '0;
  logic [W-1:0]  tmr;
  logic          period_evt;
  logic [CH-1:0] pwm_out;

  pwm_compare_unit #(
    .WIDTH(W),
    .CHANNELS(CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode_in   (mode_in),
    .period_in (period_in),
    .period_wr (period_wr),
    .duty_in   (duty_in),
    .duty_sel  (duty_sel),
    .duty_wr   (duty_wr),
    .polarity  (polarity),
    .tmr       (tmr),
    .period_evt(period_evt),
    .pwm_out   (pwm_out)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_p;              // phase index inside the current period
  bit m_fresh;          // phase 0 reached by restart, not by finishing a down slope
  bit m_mode, sh_mode;  // 0 edge, 1 center
  int m_pr, sh_pr;
  int duty_sh[CH];
  int duty_act[CH];
  bit lvl[CH];

  function automatic int m_tmr();
    if (!m_mode) return m_p;
    return (m_p <= m_pr) ? m_p : 2 * m_pr - m_p;
  endfunction

  function automatic bit m_bnd();
    if (!m_mode) return m_p == m_pr;
    return (m_pr == 0) || (m_p == 0 && !m_fresh);
  endfunction

  task automatic m_load();
    m_mode = sh_mode;
    m_pr   = sh_pr;
    for (int i = 0; i < CH; i++) duty_act[i] = duty_sh[i];
  endtask

  always @(posedge clk) begin : model
    int t;
    bit b, old_mode;
    logic [W-1:0] et;
    logic [CH-1:0] pw;
    if (rst) begin
      m_p = 0; m_fresh = 1; m_mode = 0; sh_mode = 0;
      m_pr = 65535; sh_pr = 65535;
      for (int i = 0; i < CH; i++) begin duty_sh[i] = 0; duty_act[i] = 0; lvl[i] = 0; end
    end else begin
      if (period_wr) begin sh_pr = int'(period_in); sh_mode = mode_in; end
      if (duty_wr && int'(duty_sel) < CH) duty_sh[int'(duty_sel)] = int'(duty_in);
      if (en) begin
        t = m_tmr();
        b = m_bnd();
        for (int i = 0; i < CH; i++) lvl[i] = (t < duty_act[i]);
        if (b) begin
          old_mode = m_mode;
          m_load();
          if (m_mode != old_mode || !m_mode || m_pr == 0) begin
            m_p = 0;
            m_fresh = (m_mode != old_mode);
          end else begin
            m_p = 1;
            m_fresh = 0;
          end
        end else begin
          m_p++;
          m_fresh = 0;
          if (m_mode && m_p == 2 * m_pr) m_p = 0;
        end
      end else begin
        m_load();
      end
    end
    et = W'(m_tmr());
    for (int i = 0; i < CH; i++) pw[i] = lvl[i] ^ polarity[i];
    exp_q.push_back({et, en & m_bnd(), pw});
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tmr", 32'(tmr), 32'(e[EW-1 -: W]));
      check("period_evt", 32'(period_evt), 32'(e[CH]));
      check("pwm_out", 32'(pwm_out), 32'(e[CH-1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wr_period(input logic [W-1:0] pr, input logic m);
    period_in = pr; mode_in = m; period_wr = 1'b1;
    step();
    period_wr = 1'b0;
  endtask

  task automatic wr_duty(input logic [1:0] sel, input logic [W-1:0] d);
    duty_sel = sel; duty_in = d; duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
  endtask

  // Fresh configuration at a stopped timer, then random run/pause, duty
  // writes (including the out-of-range channel) and polarity changes.
  task automatic rand_block(input int pr, input logic m, input int n);
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b0;
    wr_period(W'(pr), m);
    for (int c = 0; c < 4; c++) wr_duty(2'(c), W'($urandom_range(0, pr + 2)));
    en = 1'b1;
    repeat (n) begin
      en = ($urandom_range(0, 7) != 0);
      duty_wr = ($urandom_range(0, 3) == 0);
      duty_sel = 2'($urandom_range(0, 3));
      duty_in = W'($urandom_range(0, pr + 2));
      if ($urandom_range(0, 15) == 0) polarity = CH'($urandom_range(0, 7));
      step();
    end
    duty_wr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    run(2);
    rst = 1'b0;

    // Edge mode PR=9: ch0 duty 3, ch1 duty 2, ch2 duty 0 inverted -> constant 1.
    wr_period(W'(9), 1'b0);
    wr_duty(2'd0, W'(3));
    wr_duty(2'd1, W'(2));
    wr_duty(2'd2, W'(0));
    polarity = 3'b100;
    en = 1'b1;
    run(25);

    // Mid-period duty change only lands at the next boundary.
    wr_duty(2'd1, W'(7));
    run(22);

    // Boundaries: duty above PR, duty equal to PR, out-of-range channel.
    wr_duty(2'd0, W'(12));
    wr_duty(2'd1, W'(9));
    wr_duty(2'd3, W'(5));
    run(22);

    // Same-cycle period and duty write: switch to center PR=4, duty0=2.
    period_in = W'(4); mode_in = 1'b1; period_wr = 1'b1;
    duty_sel = 2'd0; duty_in = W'(2); duty_wr = 1'b1;
    step();
    period_wr = 1'b0; duty_wr = 1'b0;
    run(30);

    // Back to edge PR=9, then reset while tmr==5.
    wr_period(W'(9), 1'b0);
    run(20);
    for (int i = 0; i < 40 && tmr != W'(5); i++) step();
    n_checks++;
    if (tmr != W'(5)) begin
      n_errors++;
      $display("FAIL sync_tmr5: got %0d expected 5", tmr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b0;

    // Pre-start configuration, then a 5-cycle pause mid-period.
    wr_period(W'(9), 1'b0);
    wr_duty(2'd0, W'(3));
    en = 1'b1;
    run(5);
    en = 1'b0;
    run(5);
    en = 1'b1;
    run(15);

    // Randomised blocks over several periods and both modes.
    rand_block(9, 1'b0, 150);
    rand_block(4, 1'b1, 150);
    rand_block(int'($urandom_range(1, 20)), 1'b0, 150);
    rand_block(int'($urandom_range(1, 12)), 1'b1, 150);
    rand_block(0, 1'b1, 30);
    rand_block(0, 1'b0, 30);

    run(2);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
